// File: rtl/rfs_led_driver.sv
// rfs_led_driver: per-LED steady/blink/PWM/force-off output stage behind the LED PIO,
// configured through a four-word Avalon-MM slave.
module rfs_led_driver #(
    parameter logic [23:0] BLINK_DIV_RST = 24'd25000000,
    parameter int unsigned PWM_PRE       = 196,
    parameter logic [7:0]  DUTY_RST      = 8'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  led_cmd,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [3:0]  led
);

    localparam int unsigned    PreW   = (PWM_PRE > 1) ? $clog2(PWM_PRE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PWM_PRE - 1);

    typedef enum logic [1:0] {
        ModeSteady = 2'b00,
        ModeBlink  = 2'b01,
        ModePwm    = 2'b10,
        ModeOff    = 2'b11
    } mode_e;

    logic [7:0]      ctrl_q, ctrl_d;
    logic [23:0]     blink_div_q, blink_div_d;
    logic [7:0]      duty_q, duty_d;
    logic [23:0]     blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [3:0]      led_q, led_d;

    logic        wr_en, wr_ctrl, wr_div, wr_duty;
    logic [23:0] div_wdata;
    logic        pre_tick;
    logic        pwm_on;
    mode_e       mode;

    assign wr_en   = chipselect & ~write_n;
    assign wr_ctrl = wr_en & (address == 2'd0);
    assign wr_div  = wr_en & (address == 2'd1);
    assign wr_duty = wr_en & (address == 2'd2);

    // A zero half-period would never toggle; clamp it to one clock.
    assign div_wdata = (writedata[23:0] == 24'd0) ? 24'd1 : writedata[23:0];

    assign pre_tick = (pre_cnt_q == PreMax);
    assign pwm_on   = (pwm_cnt_q < duty_q);

    always_comb begin
        ctrl_d        = ctrl_q;
        blink_div_d   = blink_div_q;
        duty_d        = duty_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        pre_cnt_d     = pre_cnt_q;
        pwm_cnt_d     = pwm_cnt_q;
        led_d         = '0;
        mode          = ModeSteady;

        if (wr_ctrl) ctrl_d = writedata[7:0];
        if (wr_duty) duty_d = writedata[7:0];

        // A divider write restarts the half-period without touching the phase.
        if (wr_div) begin
            blink_div_d = div_wdata;
            blink_cnt_d = div_wdata - 24'd1;
        end else if (blink_cnt_q == 24'd0) begin
            blink_cnt_d   = blink_div_q - 24'd1;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q - 24'd1;
        end

        if (pre_tick) begin
            pre_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            pre_cnt_d = pre_cnt_q + PreW'(1);
        end

        for (int i = 0; i < 4; i++) begin
            mode = mode_e'(ctrl_q[2*i +: 2]);
            unique case (mode)
                ModeSteady: led_d[i] = led_cmd[i];
                ModeBlink:  led_d[i] = led_cmd[i] & blink_phase_q;
                ModePwm:    led_d[i] = led_cmd[i] & pwm_on;
                ModeOff:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= 8'd0;
            blink_div_q   <= BLINK_DIV_RST;
            duty_q        <= DUTY_RST;
            blink_cnt_q   <= BLINK_DIV_RST - 24'd1;
            blink_phase_q <= 1'b0;
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= 8'd0;
            led_q         <= 4'd0;
        end else begin
            ctrl_q        <= ctrl_d;
            blink_div_q   <= blink_div_d;
            duty_q        <= duty_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_q         <= led_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        unique case (address)
            2'd0: readdata = {24'd0, ctrl_q};
            2'd1: readdata = {8'd0, blink_div_q};
            2'd2: readdata = {24'd0, duty_q};
            2'd3: readdata = {12'd0, led_q, pwm_cnt_q, 7'd0, blink_phase_q};
        endcase
    end

    assign led = led_q;

endmodule

// File: tb/tb_rfs_led_driver.sv
// Self-checking bench for rfs_led_driver: a cycle model queues the expected led value per clock,
// and each test task pops and compares after the edge.
module tb_rfs_led_driver;

    localparam logic [23:0] BlinkDivRst = 24'd25000000;
    localparam int unsigned PwmPre      = 1;
    localparam logic [7:0]  DutyRst     = 8'd32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  led_cmd = 4'd0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  led;

    rfs_led_driver #(
        .BLINK_DIV_RST(BlinkDivRst),
        .PWM_PRE      (PwmPre),
        .DUTY_RST     (DutyRst)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_cmd   (led_cmd),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .led       (led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    // Reference state of the register file and counters
    logic [7:0]  m_ctrl, m_duty, m_pwm;
    logic [23:0] m_div, m_bcnt;
    logic        m_phase;
    logic [3:0]  m_led;
    int unsigned m_pre;

    task automatic model_reset();
        m_ctrl = 8'd0; m_duty = DutyRst; m_pwm = 8'd0;
        m_div = BlinkDivRst; m_bcnt = BlinkDivRst - 24'd1;
        m_phase = 1'b0; m_led = 4'd0; m_pre = 0;
        exp_q.delete();
    endtask

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic step(input bit record);
        logic [3:0]  nled;
        logic [23:0] nd;
        logic [1:0]  md;
        for (int i = 0; i < 4; i++) begin
            md = m_ctrl[2*i +: 2];
            case (md)
                2'b00:   nled[i] = led_cmd[i];
                2'b01:   nled[i] = led_cmd[i] & m_phase;
                2'b10:   nled[i] = led_cmd[i] & (m_pwm < m_duty);
                default: nled[i] = 1'b0;
            endcase
        end
        if (record) exp_q.push_back(nled);
        if (chipselect && !write_n && address == 2'd1) begin
            nd = writedata[23:0];
            if (nd == 24'd0) nd = 24'd1;
            m_div  = nd;
            m_bcnt = nd - 24'd1;
        end else if (m_bcnt == 24'd0) begin
            m_bcnt  = m_div - 24'd1;
            m_phase = ~m_phase;
        end else begin
            m_bcnt = m_bcnt - 24'd1;
        end
        if (m_pre == PwmPre - 1) begin
            m_pre = 0;
            m_pwm = m_pwm + 8'd1;
        end else begin
            m_pre = m_pre + 1;
        end
        if (chipselect && !write_n && address == 2'd0) m_ctrl = writedata[7:0];
        if (chipselect && !write_n && address == 2'd2) m_duty = writedata[7:0];
        m_led = nled;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step(1'b0);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (led !== 4'd0) begin
            n_fail++; $display("FAIL reset_led: led=%b required 0000", led);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            rd = (a == 1) ? {8'd0, BlinkDivRst} : (a == 2) ? {24'd0, DutyRst} : 32'd0;
            n_tests++;
            if (readdata !== rd) begin
                n_fail++; $display("FAIL reset_reg%0d: read %h required %h", a, readdata, rd);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_steady();
        logic [3:0] e;
        led_cmd = 4'b1010;
        step(1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if (led !== e || led !== 4'b1010) begin
            n_fail++; $display("FAIL steady: led=%b required %b", led, e);
        end
        address = 2'd0;
        #1;
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL ctrl_read: read %h required 00000000", readdata);
        end
    endtask

    task automatic test_blink();
        logic [3:0] e;
        led_cmd = 4'b0001;
        do_write(2'd0, 32'h1);
        do_write(2'd1, 32'd4);
        for (int k = 0; k < 18; k++) begin
            step(1'b1);
            e = exp_q.pop_front();
            n_tests++;
            if (led !== e || led[0] !== 1'((k / 4) % 2)) begin
                n_fail++;
                $display("FAIL blink4 cyc %0d: led=%b required %b (led0 %0d)", k, led, e, (k / 4) % 2);
            end
        end
        do_write(2'd1, 32'd2);
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            e = exp_q.pop_front();
            n_tests++;
            if (led !== e) begin
                n_fail++; $display("FAIL blink2 cyc %0d: led=%b required %b", k, led, e);
            end
        end
    endtask

    task automatic test_pwm();
        logic [3:0] e;
        int         highs;
        logic [7:0] duties[3];
        int         want[3];
        duties[0] = 8'd64;  want[0] = 64;
        duties[1] = 8'd0;   want[1] = 0;
        duties[2] = 8'd255; want[2] = 255;
        led_cmd = 4'b0010;
        do_write(2'd0, 32'h8);
        for (int t = 0; t < 3; t++) begin
            do_write(2'd2, {24'd0, duties[t]});
            step(1'b1);
            void'(exp_q.pop_front());
            highs = 0;
            for (int k = 0; k < 256; k++) begin
                step(1'b1);
                e = exp_q.pop_front();
                if (led[1] === 1'b1) highs++;
                n_tests++;
                if (led !== e) begin
                    n_fail++;
                    $display("FAIL pwm duty %0d cyc %0d: led=%b required %b", duties[t], k, led, e);
                end
            end
            n_tests++;
            if (highs != want[t]) begin
                n_fail++;
                $display("FAIL pwm_count duty %0d: high %0d of 256 required %0d", duties[t], highs, want[t]);
            end
        end
    endtask

    task automatic test_force_off();
        logic [3:0]  e;
        logic [31:0] rd;
        led_cmd = 4'hF;
        do_write(2'd0, 32'hC0);
        step(1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if (led !== e || led !== 4'b0111) begin
            n_fail++; $display("FAIL force_off: led=%b required 0111", led);
        end
        do_write(2'd3, 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            case (a)
                0: rd = 32'h0000_00C0;
                1: rd = 32'h0000_0002;
                2: rd = 32'h0000_00FF;
                default: rd = {12'd0, m_led, m_pwm, 7'd0, m_phase};
            endcase
            n_tests++;
            if (readdata !== rd) begin
                n_fail++; $display("FAIL ro_write reg%0d: read %h required %h", a, readdata, rd);
            end
        end
        n_tests++;
        if (readdata[19:16] !== 4'b0111) begin
            n_fail++; $display("FAIL status_led: read %b required 0111", readdata[19:16]);
        end
    endtask

    task automatic test_div_zero();
        logic [3:0] e;
        logic       prev;
        do_write(2'd1, 32'd0);
        address = 2'd1;
        #1;
        n_tests++;
        if (readdata !== 32'd1) begin
            n_fail++; $display("FAIL div_zero_read: read %h required 00000001", readdata);
        end
        led_cmd = 4'b0001;
        do_write(2'd0, 32'h1);
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1);
            e = exp_q.pop_front();
            n_tests++;
            if (led !== e || (k > 0 && led[0] === prev)) begin
                n_fail++; $display("FAIL div1_blink cyc %0d: led=%b required %b", k, led, e);
            end
            prev = led[0];
        end
        do_write(2'd1, 32'hFF12_3456);
        address = 2'd1;
        #1;
        n_tests++;
        if (readdata !== 32'h0012_3456) begin
            n_fail++; $display("FAIL div_trunc: read %h required 00123456", readdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        do_write(2'd1, 32'd3);
        led_cmd = 4'hF;
        do_write(2'd0, 32'h55);
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            e = exp_q.pop_front();
            n_tests++;
            if (led !== e) begin
                n_fail++; $display("FAIL mid_blink cyc %0d: led=%b required %b", k, led, e);
            end
            if (m_led == 4'hF) break;
        end
        n_tests++;
        if (led !== 4'hF) begin
            n_fail++; $display("FAIL pre_reset: led=%b required 1111", led);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (led !== 4'd0) begin
            n_fail++; $display("FAIL async_reset: led=%b required 0000", led);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        address = 2'd0;
        #1;
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_ctrl: read %h required 00000000", readdata);
        end
        address = 2'd1;
        #1;
        n_tests++;
        if (readdata !== {8'd0, BlinkDivRst}) begin
            n_fail++; $display("FAIL post_reset_div: read %h required %h", readdata, {8'd0, BlinkDivRst});
        end
        address = 2'd2;
        #1;
        n_tests++;
        if (readdata !== 32'd32) begin
            n_fail++; $display("FAIL post_reset_duty: read %h required 00000020", readdata);
        end
        step(1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if (led !== e) begin
            n_fail++; $display("FAIL post_reset_led: led=%b required %b", led, e);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_blink();
        test_pwm();
        test_force_off();
        test_div_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
